clk_en_gen_multi: RTL and testbench

CLK_EN_GEN_MULTI -- requirements
Module: clk_en_gen_multi

---
 rtl/clk_gen_pkg.sv | 19 +
 rtl/clk_div_ch.sv | 97 +++++++++
 rtl/clk_en_gen_multi.sv | 186 ++++++++++++++++++
 tb/tb_clk_en_gen_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_gen_pkg
// Shared definitions for the multi-channel clock-enable generator:
//   - seq_state_t : lock sequencer state encoding (IDLE / COUNT / RUN)
//   - DIV_W_DEF   : default divide-ratio width
//   - CNT_W_DEF   : default free-running counter width
// ---------------------------------------------------------------------------
package clk_gen_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_t;

endpackage : clk_gen_pkg

// File: rtl/clk_div_ch.sv
// ---------------------------------------------------------------------------
// clk_div_ch
// One divider channel: period counter, active ratio, pending ratio, ce strobe
// and a 50% square wave that toggles with every ce.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   run_now    : sequencer is in RUN this cycle
//   run_next   : sequencer stays in / enters RUN at this edge
//   sync_req   : phase realign (already qualified with RUN)
//   cfg_we     : accepted cfg transfer targeting this channel
//   cfg_val    : new ratio (already mapped 0 -> 1)
//   pending    : a ratio update waits for the next terminal count
//   ce, clk_q  : registered strobe and square wave
// ---------------------------------------------------------------------------
module clk_div_ch
    import clk_gen_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV_INIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_now,
    input  logic             run_next,
    input  logic             sync_req,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_val,
    output logic             pending,
    output logic             ce,
    output logic             clk_q
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] ratio_r;
    logic [DIV_W-1:0] pend_ratio_r;
    logic             pend_r;
    logic             ce_r;
    logic             clk_q_r;
    logic             restart_s;
    logic             tc_s;

    // Restart covers: not running, leaving RUN, entering RUN and sync realign.
    always_comb begin
        restart_s = !run_now || !run_next || sync_req;
        tc_s      = (cnt_r == (ratio_r - DIV_W'(1)));
    end

    // Channel counter, ratio handling and strobe generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= '0;
            ratio_r      <= DIV_W'(DIV_INIT);
            pend_ratio_r <= '0;
            pend_r       <= 1'b0;
            ce_r         <= 1'b0;
            clk_q_r      <= 1'b0;
        end else if (restart_s) begin
            // A fresh phase starts; any waiting ratio takes effect right away,
            // a transfer in this same cycle wins over an older pending value.
            cnt_r   <= '0;
            ce_r    <= 1'b0;
            clk_q_r <= 1'b0;
            pend_r  <= 1'b0;
            if (cfg_we) begin
                ratio_r <= cfg_val;
            end else if (pend_r) begin
                ratio_r <= pend_ratio_r;
            end else begin
                ratio_r <= ratio_r;
            end
        end else begin
            if (tc_s) begin
                cnt_r   <= '0;
                ce_r    <= 1'b1;
                clk_q_r <= ~clk_q_r;
                if (pend_r) begin
                    ratio_r <= pend_ratio_r;
                    pend_r  <= 1'b0;
                end
            end else begin
                cnt_r <= cnt_r + DIV_W'(1);
                ce_r  <= 1'b0;
            end
            // The current period always completes with the old ratio; the new
            // one waits for the following terminal count.
            if (cfg_we) begin
                pend_r       <= 1'b1;
                pend_ratio_r <= cfg_val;
            end
        end
    end

    assign pending = pend_r;
    assign ce      = ce_r;
    assign clk_q   = clk_q_r;

endmodule : clk_div_ch

// File: rtl/clk_en_gen_multi.sv
// ---------------------------------------------------------------------------
// clk_en_gen_multi
// Multi-channel clock-enable generator gated by an MMCM lock sequencer.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   locked     : MMCM lock (asynchronous, synchronized internally)
//   cfg_valid  : divide-update request; cfg_ready accepts it (combinational)
//   cfg_ch     : target channel; cfg_div : new ratio (0 treated as 1)
//   sync       : phase realign pulse, effective only in RUN
//   ready      : sequencer is in RUN (registered)
//   div        : free-running cycle counter
//   ce, clk_q  : per-channel strobes and square waves
// ---------------------------------------------------------------------------
module clk_en_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CYC = 16,
    parameter int DIV_INIT = 2,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic              ready,
    output logic [CNT_W-1:0]  div,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_q
);

    localparam int LC_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC + 1) : 1;
    localparam int CH_N = 2 ** CH_W;

    logic              locked_meta_r;
    logic              locked_sync_r;
    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic [LC_W-1:0]   lock_cnt_r;
    logic [LC_W-1:0]   lock_cnt_nxt_s;
    logic              ready_r;
    logic [CNT_W-1:0]  div_cnt_r;
    logic [NUM_CH-1:0] pend_s;
    logic [CH_N-1:0]   pend_pad_s;
    logic [DIV_W-1:0]  cfg_val_s;
    logic              run_now_s;
    logic              run_next_s;
    logic              sync_req_s;
    logic [NUM_CH-1:0] ce_s;
    logic [NUM_CH-1:0] clk_q_s;

    // Two-flop synchronizer for the asynchronous lock status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_meta_r <= 1'b0;
            locked_sync_r <= 1'b0;
        end else begin
            locked_meta_r <= locked;
            locked_sync_r <= locked_meta_r;
        end
    end

    // Sequencer next state; lock_cnt holds the number of consecutive locked
    // cycles seen so far, so RUN is entered on the LOCK_CYC-th one.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (locked_sync_r) begin
                    if (LOCK_CYC <= 1) begin
                        state_nxt_s    = ST_RUN;
                        lock_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s    = ST_COUNT;
                        lock_cnt_nxt_s = LC_W'(1);
                    end
                end else begin
                    lock_cnt_nxt_s = '0;
                end
            end
            ST_COUNT: begin
                if (!locked_sync_r) begin
                    state_nxt_s    = ST_IDLE;
                    lock_cnt_nxt_s = '0;
                end else if (lock_cnt_r >= LC_W'(LOCK_CYC - 1)) begin
                    state_nxt_s    = ST_RUN;
                    lock_cnt_nxt_s = '0;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r + LC_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_sync_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
                lock_cnt_nxt_s = '0;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                lock_cnt_nxt_s = '0;
            end
        endcase
    end

    // Sequencer state, lock counter and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= '0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            ready_r    <= (state_nxt_s == ST_RUN);
        end
    end

    // Free-running cycle counter, independent of the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // Channel control shared by all channels; a zero ratio means divide-by-1.
    always_comb begin
        run_now_s  = (state_r == ST_RUN);
        run_next_s = (state_nxt_s == ST_RUN);
        sync_req_s = sync && run_now_s;
        if (cfg_div == '0) begin
            cfg_val_s = DIV_W'(1);
        end else begin
            cfg_val_s = cfg_div;
        end
    end

    // Pending bits padded to the full cfg_ch range: unused indices read 0,
    // so an out-of-range channel is always ready and matches no channel.
    always_comb begin
        pend_pad_s = CH_N'(pend_s);
    end

    assign cfg_ready = !pend_pad_s[cfg_ch];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic cfg_we_s;

        // Transfer strobe for this channel.
        always_comb begin
            cfg_we_s = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
        end

        clk_div_ch #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .run_now  (run_now_s),
            .run_next (run_next_s),
            .sync_req (sync_req_s),
            .cfg_we   (cfg_we_s),
            .cfg_val  (cfg_val_s),
            .pending  (pend_s[g]),
            .ce       (ce_s[g]),
            .clk_q    (clk_q_s[g])
        );
    end

    assign ready = ready_r;
    assign div   = div_cnt_r;
    assign ce    = ce_s;
    assign clk_q = clk_q_s;

endmodule : clk_en_gen_multi

// File: tb/tb_clk_en_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_en_gen_multi
// Scoreboard bench: a reference model, written in terms of lock streaks and
// absolute strobe times, pushes the expected outputs after every clock edge;
// a separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_clk_en_gen_multi;

    localparam int NCH      = 3;
    localparam int DIV_W    = 16;
    localparam int CNT_W    = 4;
    localparam int LOCK_CYC = 16;
    localparam int DIV_INIT = 2;
    localparam int CH_W     = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             locked;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             sync;
    logic             ready;
    logic [CNT_W-1:0] div;
    logic [NCH-1:0]   ce;
    logic [NCH-1:0]   clk_q;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic             ready;
        logic [NCH-1:0]   ce;
        logic [NCH-1:0]   clk_q;
        logic [CNT_W-1:0] div;
        logic [NCH-1:0]   pend;
    } exp_t;

    exp_t exp_q[$];

    clk_en_gen_multi #(
        .NUM_CH   (NCH),
        .DIV_W    (DIV_W),
        .CNT_W    (CNT_W),
        .LOCK_CYC (LOCK_CYC),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .sync      (sync),
        .ready     (ready),
        .div       (div),
        .ce        (ce),
        .clk_q     (clk_q)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int edge_no = 0;
    bit lk1 = 1'b0, lk2 = 1'b0;
    int streak = 0;
    bit m_ready = 1'b0;
    int m_div = 0;
    int m_n[NCH];
    bit m_pend[NCH];
    int m_pend_n[NCH];
    int m_next[NCH];
    bit m_ce[NCH];
    bit m_q[NCH];

    task automatic model_reset();
        lk1 = 1'b0; lk2 = 1'b0; streak = 0; m_ready = 1'b0; m_div = 0;
        for (int c = 0; c < NCH; c++) begin
            m_n[c] = DIV_INIT; m_pend[c] = 1'b0; m_pend_n[c] = 0;
            m_next[c] = 0; m_ce[c] = 1'b0; m_q[c] = 1'b0;
        end
    endtask

    always @(posedge clk) begin : model_p
        bit   s, run_prev, run_new, xfer, sync_eff;
        int   nv, ch;
        exp_t e;
        edge_no++;
        if (rst) begin
            model_reset();
        end else begin
            // synchronized lock seen by the sequencer = locked two edges ago
            s   = lk2;
            lk2 = lk1;
            lk1 = locked;
            streak   = s ? streak + 1 : 0;
            run_prev = m_ready;
            run_new  = (streak >= LOCK_CYC);
            nv       = (cfg_div == '0) ? 1 : int'(cfg_div);
            ch       = int'(cfg_ch);
            xfer     = 1'b0;
            if (cfg_valid && ch < NCH) xfer = !m_pend[ch];
            sync_eff = sync && run_prev;
            for (int c = 0; c < NCH; c++) begin
                if (!run_prev || !run_new || sync_eff) begin
                    m_ce[c] = 1'b0;
                    m_q[c]  = 1'b0;
                    if (xfer && ch == c) m_n[c] = nv;
                    else if (m_pend[c]) m_n[c] = m_pend_n[c];
                    m_pend[c] = 1'b0;
                    m_next[c] = edge_no + m_n[c];
                end else begin
                    if (edge_no == m_next[c]) begin
                        m_ce[c] = 1'b1;
                        m_q[c]  = !m_q[c];
                        if (m_pend[c]) begin
                            m_n[c]    = m_pend_n[c];
                            m_pend[c] = 1'b0;
                        end
                        m_next[c] = edge_no + m_n[c];
                    end else begin
                        m_ce[c] = 1'b0;
                    end
                    if (xfer && ch == c) begin
                        m_pend[c]   = 1'b1;
                        m_pend_n[c] = nv;
                    end
                end
            end
            m_ready = run_new;
            m_div   = (m_div + 1) % (1 << CNT_W);
        end
        e.ready = m_ready;
        e.div   = CNT_W'(m_div);
        for (int c = 0; c < NCH; c++) begin
            e.ce[c]    = m_ce[c];
            e.clk_q[c] = m_q[c];
            e.pend[c]  = m_pend[c];
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor_p
        exp_t       e;
        logic [3:0] pp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                // while reset is asserted everything reads its reset value
                if (rst) e = '0;
                pp = {1'b0, e.pend};
                chk("ready", 32'(ready), 32'(e.ready));
                chk("ce", 32'(ce), 32'(e.ce));
                chk("clk_q", 32'(clk_q), 32'(e.clk_q));
                chk("div", 32'(div), 32'(e.div));
                chk("cfg_ready", 32'(cfg_ready), 32'(!pp[cfg_ch]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim_p
        rst = 1'b1; locked = 1'b0; cfg_valid = 1'b0; sync = 1'b0;
        cfg_ch = '0; cfg_div = '0;
        tick(3);
        rst = 1'b0;
        tick(4);
        // lock with defaults, run a while
        locked = 1'b1;
        tick(30);
        // ch1 -> N=5 mid-period, hold cfg_ch to watch cfg_ready
        cfg_ch = 2'd1; cfg_div = 16'd5; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(20);
        // ch2 -> N=3 together with sync
        cfg_ch = 2'd2; cfg_div = 16'd3; cfg_valid = 1'b1; sync = 1'b1;
        tick(1);
        cfg_valid = 1'b0; sync = 1'b0;
        tick(12);
        // one-cycle lock drop
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(30);
        // ch0 -> N=0 (divide by 1), then out-of-range channel
        cfg_ch = 2'd0; cfg_div = 16'd0; cfg_valid = 1'b1;
        tick(1);
        cfg_ch = 2'd3; cfg_div = 16'd7;
        tick(1);
        cfg_valid = 1'b0;
        tick(10);
        // cfg outside RUN loads at once
        locked = 1'b0;
        tick(5);
        cfg_ch = 2'd1; cfg_div = 16'd4; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0; locked = 1'b1;
        tick(30);
        // reset in the middle of RUN
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(25);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_div   = DIV_W'($urandom_range(0, 6));
            sync      = ($urandom_range(0, 39) == 0);
            if (locked) begin
                if ($urandom_range(0, 149) == 0) locked = 1'b0;
            end else begin
                if ($urandom_range(0, 5) == 0) locked = 1'b1;
            end
            rst = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        rst = 1'b0; cfg_valid = 1'b0; sync = 1'b0;
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_en_gen_multi
